aib_axi_lite_bridge: RTL and testbench
======================================

// Module: aib_axi_lite_bridge
// PURPOSE
//  Single-clock, credit-based AXI4-Lite bridge that models a die-to-die AIB link between a master-side user AXI port
//  and a slave-side user AXI port. AW/W/AR travel master->slave and R/B travel slave->master, each over a fixed-latency
//  link pipe feeding a receive FIFO. Replaces the multi-clock AIB PHY stack for system-level bring-up and simulation.
// PARAMETERS
//  ADDR_W    32  address width (aw/ar)
//  DATA_W    64  data width (w/r); strobe width = DATA_W/8
//  ID_W       4  aw/ar/b/r id width
//  LINK_LAT   4  link pipe stages, each direction (>=1)
//  RX_DEPTH  16  per-channel receive FIFO depth = max credits (power of 2)
// PORTS
//  m_clk_wr            in  1      sole clock for the whole block
//  m_rst_wr_n          in  1      async active-low reset
//  i_conf_done         in  1      AIB config complete
//  m_tx_online,m_rx_online,s_tx_online,s_rx_online  in 1 each  link-side online flags
//  m_init_ar_credit,m_init_aw_credit,m_init_w_credit  in 8  initial AR/AW/W credits
//  s_init_r_credit,s_init_b_credit  in 8  initial R/B credits
//  m_aw{valid,addr,id,len,size,burst} in / m_awready out   master write-address (len/size/burst carried verbatim)
//  m_w{valid,data,strb,last} in / m_wready out               master write data
//  m_b{valid,resp,id} out / m_bready in                      master write response
//  m_ar{valid,addr,id,len,size,burst} in / m_arready out     master read address
//  m_r{valid,data,resp,id,last} out / m_rready in            master read data
//  s_* : same five channels, mirrored direction (slave side drives aw/w/ar ready inputs, b/r valid inputs)
//  link_up             out 1      AND of i_conf_done and all four online flags
// BEHAVIOUR
//  - Reset: all *valid/*ready outputs 0, credit counters 0, pipes and FIFOs empty, link_up 0.
//  - Credits: on the first cycle link_up is 1 after reset, each channel credit loads its init value, saturated to
//    RX_DEPTH; init 0 means the channel is permanently blocked. Credits are loaded only once per reset.
//  - Sender side (m_aw/m_w/m_ar, s_r/s_b): ready = link_up && credit!=0 (combinational); handshake = valid&&ready.
//    Handshake decrements credit and pushes the payload into the LINK_LAT-stage pipe.
//  - Latency: payload accepted at edge N appears as far-side valid after edge N+LINK_LAT+1 (pipe then FIFO write);
//    the FIFO is first-word-fall-through, so valid and payload are held stable until ready.
//  - Receiver side: valid = FIFO not empty. Pop on valid&&ready; each pop returns one credit through a LINK_LAT-stage
//    return pipe, so the credit increments LINK_LAT cycles after the pop.
//  - Same-cycle credit decrement and increment: net unchanged. Credit never exceeds RX_DEPTH, never wraps below 0;
//    FIFO overflow is impossible by construction (the assertion must fire if it happens).
//  - link_up falling: new sender handshakes stop at once; in-flight pipe contents and FIFO data are still delivered;
//    credits are frozen, then resume counting when link_up rises.
//  - Channels are independent: no AW/W ordering or merging; FIFO order is preserved per channel.
//  - Async reset mid-transfer discards all in-flight beats and credits; after reset, credits reload when link_up rises.
// STRUCTURE
//  - Package aib_axi_lite_pkg: ADDR_W/DATA_W/ID_W defaults and packed structs for AW/AR, W, B and R payloads.
//  - Sub-module aib_axi_lite_chan #(PAYLOAD_W,LINK_LAT,RX_DEPTH): credit counter, forward pipe, FIFO, credit-return
//    pipe. Instantiated 5 times: AW, W, AR (master->slave) and R, B (slave->master).
// TESTING
//  - Bring-up: release reset at 100 ns, conf_done/online set 20 ns later, credits 8 -> m_awready=m_wready=m_arready=1
//    one cycle after link_up; m_bvalid=m_rvalid=0.
//  - Write: awaddr=0x1000, wdata=0x12345678, wstrb=0xFF -> s_awvalid/s_wvalid with the same payload exactly
//    LINK_LAT+1 cycles later; s_bresp=0 -> m_bvalid with bresp=0 LINK_LAT+1 cycles after the s_b handshake.
//  - Read: araddr=0x2000 -> s_araddr=0x2000; s_rdata=0x9ABCDEF0, rresp=0 -> m_rdata=0x9ABCDEF0, m_rresp=0.
//  - Credit stall: m_init_aw_credit=2, s_awready=0, 3 AWs -> m_awready=0 after the 2nd; raise s_awready -> third
//    accepted LINK_LAT cycles after the first pop.
//  - Link drop: clear s_rx_online with an AW in flight -> m_awready=0 at once, in-flight AW still delivered.
//  - Reset mid-burst: assert m_rst_wr_n=0 with beats queued -> all valids 0 immediately; after re-link, credits = init.

Source files
------------

// File: rtl/aib_axi_lite_bridge_pkg.sv
// Shared widths and payload layouts for the AIB AXI4-Lite bridge.
// The structs describe the beat layout each link channel carries at the default widths.
package aib_axi_lite_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;
  localparam int CREDIT_W   = 8;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_req_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_req_t;

  typedef struct packed {
    logic [1:0]          resp;
    logic [AXI_ID_W-1:0] id;
  } b_rsp_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic [AXI_ID_W-1:0]   id;
    logic                  last;
  } r_rsp_t;
endpackage

// File: rtl/aib_axi_lite_bridge_if.sv
// One AXI4-Lite port (five channels). master = user initiator view, slave = responder view.
interface aib_axi_lite_bridge_if #(
  parameter int ADDR_W = aib_axi_lite_pkg::AXI_ADDR_W,
  parameter int DATA_W = aib_axi_lite_pkg::AXI_DATA_W,
  parameter int ID_W   = aib_axi_lite_pkg::AXI_ID_W
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rid, rlast, output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rid, rlast, input rready
  );
endinterface

// File: rtl/aib_axi_lite_bridge_chan.sv
// One credited link channel: sender credit counter, forward pipe, FWFT receive FIFO,
// and the pipe that carries freed FIFO slots back to the sender as credits.
module aib_axi_lite_chan
  import aib_axi_lite_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int LINK_LAT  = 4,
  parameter int RX_DEPTH  = 16
) (
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 link_up,
  input  logic [CREDIT_W-1:0]  init_credit,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [PAYLOAD_W-1:0] rx_payload
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CR = CW'(RX_DEPTH);

  logic [CW-1:0] credit, cr_hold, cr_init;
  logic [CW:0]   cr_sum;
  logic          loaded, push, pop, ret, fifo_wr, full;

  logic [LINK_LAT:0]                vld_pipe;
  logic [LINK_LAT:0][PAYLOAD_W-1:0] dat_pipe;
  logic [LINK_LAT-1:0]              ret_pipe;

  logic [PAYLOAD_W-1:0] mem [RX_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;

  assign tx_ready = link_up && (credit != '0);
  assign push     = tx_valid && tx_ready;
  assign pop      = rx_valid && rx_ready;
  assign ret      = ret_pipe[LINK_LAT-1];
  assign cr_init  = (init_credit > CREDIT_W'(RX_DEPTH)) ? MAX_CR : CW'(init_credit);
  assign cr_sum   = {1'b0, credit} - (CW+1)'(push) + (CW+1)'(ret) + {1'b0, cr_hold};

  // Credits freeze while the link is down; returns arriving then are parked in cr_hold.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      credit  <= '0;
      cr_hold <= '0;
      loaded  <= 1'b0;
    end else if (!loaded) begin
      if (link_up) begin
        credit <= cr_init;
        loaded <= 1'b1;
      end
    end else if (link_up) begin
      credit  <= (cr_sum > (CW+1)'(RX_DEPTH)) ? MAX_CR : cr_sum[CW-1:0];
      cr_hold <= '0;
    end else if (ret) begin
      cr_hold <= cr_hold + CW'(1);
    end
  end

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[LINK_LAT-1:0], push};

  always_ff @(posedge gclk) dat_pipe <= {dat_pipe[LINK_LAT-1:0], tx_payload};

  if (LINK_LAT == 1) begin : g_ret1
    always_ff @(posedge gclk or negedge grst_n)
      if (!grst_n) ret_pipe <= '0;
      else         ret_pipe <= pop;
  end else begin : g_retn
    always_ff @(posedge gclk or negedge grst_n)
      if (!grst_n) ret_pipe <= '0;
      else         ret_pipe <= {ret_pipe[LINK_LAT-2:0], pop};
  end

  assign fifo_wr    = vld_pipe[LINK_LAT];
  assign rx_valid   = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_payload = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge gclk) if (fifo_wr) mem[wr_ptr[AW-1:0]] <= dat_pipe[LINK_LAT];

  // Credits bound the beats in flight, so a write into a full FIFO means the credit loop broke.
  a_no_overflow: assert property (@(posedge gclk) disable iff (!grst_n) !(fifo_wr && full));
endmodule

// File: rtl/aib_axi_lite_bridge.sv
// Single-clock credited AXI4-Lite bridge standing in for an AIB die-to-die link.
// AW/W/AR flow master->slave, R/B flow slave->master, each through its own credited channel.
module aib_axi_lite_bridge
  import aib_axi_lite_pkg::*;
#(
  parameter int ADDR_W   = AXI_ADDR_W,
  parameter int DATA_W   = AXI_DATA_W,
  parameter int ID_W     = AXI_ID_W,
  parameter int LINK_LAT = 4,
  parameter int RX_DEPTH = 16
) (
  input  logic                m_clk_wr,
  input  logic                m_rst_wr_n,
  input  logic                i_conf_done,
  input  logic                m_tx_online,
  input  logic                m_rx_online,
  input  logic                s_tx_online,
  input  logic                s_rx_online,
  input  logic [CREDIT_W-1:0] m_init_ar_credit,
  input  logic [CREDIT_W-1:0] m_init_aw_credit,
  input  logic [CREDIT_W-1:0] m_init_w_credit,
  input  logic [CREDIT_W-1:0] s_init_r_credit,
  input  logic [CREDIT_W-1:0] s_init_b_credit,
  aib_axi_lite_bridge_if.slave  m_axi,
  aib_axi_lite_bridge_if.master s_axi,
  output logic                link_up
);
  localparam int AX_W = ADDR_W + ID_W + 13;
  localparam int W_W  = DATA_W + DATA_W/8 + 1;
  localparam int B_W  = ID_W + 2;
  localparam int R_W  = DATA_W + ID_W + 3;

  logic            out_of_rst;
  logic [AX_W-1:0] aw_tx, aw_rx, ar_tx, ar_rx;
  logic [W_W-1:0]  w_tx, w_rx;
  logic [B_W-1:0]  b_tx, b_rx;
  logic [R_W-1:0]  r_tx, r_rx;

  // Keeps link_up low through reset even if the online flags are already high.
  always_ff @(posedge m_clk_wr or negedge m_rst_wr_n)
    if (!m_rst_wr_n) out_of_rst <= 1'b0;
    else             out_of_rst <= 1'b1;

  assign link_up = out_of_rst && i_conf_done && m_tx_online && m_rx_online && s_tx_online && s_rx_online;

  assign aw_tx = {m_axi.awaddr, m_axi.awid, m_axi.awlen, m_axi.awsize, m_axi.awburst};
  assign {s_axi.awaddr, s_axi.awid, s_axi.awlen, s_axi.awsize, s_axi.awburst} = aw_rx;
  assign ar_tx = {m_axi.araddr, m_axi.arid, m_axi.arlen, m_axi.arsize, m_axi.arburst};
  assign {s_axi.araddr, s_axi.arid, s_axi.arlen, s_axi.arsize, s_axi.arburst} = ar_rx;
  assign w_tx  = {m_axi.wdata, m_axi.wstrb, m_axi.wlast};
  assign {s_axi.wdata, s_axi.wstrb, s_axi.wlast} = w_rx;
  assign b_tx  = {s_axi.bresp, s_axi.bid};
  assign {m_axi.bresp, m_axi.bid} = b_rx;
  assign r_tx  = {s_axi.rdata, s_axi.rresp, s_axi.rid, s_axi.rlast};
  assign {m_axi.rdata, m_axi.rresp, m_axi.rid, m_axi.rlast} = r_rx;

  aib_axi_lite_chan #(.PAYLOAD_W(AX_W), .LINK_LAT(LINK_LAT), .RX_DEPTH(RX_DEPTH)) u_aw (
    .gclk(m_clk_wr), .grst_n(m_rst_wr_n), .link_up(link_up), .init_credit(m_init_aw_credit),
    .tx_valid(m_axi.awvalid), .tx_ready(m_axi.awready), .tx_payload(aw_tx),
    .rx_valid(s_axi.awvalid), .rx_ready(s_axi.awready), .rx_payload(aw_rx));

  aib_axi_lite_chan #(.PAYLOAD_W(W_W), .LINK_LAT(LINK_LAT), .RX_DEPTH(RX_DEPTH)) u_w (
    .gclk(m_clk_wr), .grst_n(m_rst_wr_n), .link_up(link_up), .init_credit(m_init_w_credit),
    .tx_valid(m_axi.wvalid), .tx_ready(m_axi.wready), .tx_payload(w_tx),
    .rx_valid(s_axi.wvalid), .rx_ready(s_axi.wready), .rx_payload(w_rx));

  aib_axi_lite_chan #(.PAYLOAD_W(AX_W), .LINK_LAT(LINK_LAT), .RX_DEPTH(RX_DEPTH)) u_ar (
    .gclk(m_clk_wr), .grst_n(m_rst_wr_n), .link_up(link_up), .init_credit(m_init_ar_credit),
    .tx_valid(m_axi.arvalid), .tx_ready(m_axi.arready), .tx_payload(ar_tx),
    .rx_valid(s_axi.arvalid), .rx_ready(s_axi.arready), .rx_payload(ar_rx));

  aib_axi_lite_chan #(.PAYLOAD_W(R_W), .LINK_LAT(LINK_LAT), .RX_DEPTH(RX_DEPTH)) u_r (
    .gclk(m_clk_wr), .grst_n(m_rst_wr_n), .link_up(link_up), .init_credit(s_init_r_credit),
    .tx_valid(s_axi.rvalid), .tx_ready(s_axi.rready), .tx_payload(r_tx),
    .rx_valid(m_axi.rvalid), .rx_ready(m_axi.rready), .rx_payload(r_rx));

  aib_axi_lite_chan #(.PAYLOAD_W(B_W), .LINK_LAT(LINK_LAT), .RX_DEPTH(RX_DEPTH)) u_b (
    .gclk(m_clk_wr), .grst_n(m_rst_wr_n), .link_up(link_up), .init_credit(s_init_b_credit),
    .tx_valid(s_axi.bvalid), .tx_ready(s_axi.bready), .tx_payload(b_tx),
    .rx_valid(m_axi.bvalid), .rx_ready(m_axi.bready), .rx_payload(b_rx));
endmodule

// File: tb/tb_aib_axi_lite_bridge.sv
// Directed bring-up/write/read/link-drop/reset/credit tests plus randomized AW traffic
// scored against a timestamp model of credits and link latency.
module tb_aib_axi_lite_bridge;
  localparam int LAT   = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic conf_done = 1'b0, m_tx_on = 1'b0, m_rx_on = 1'b0, s_tx_on = 1'b0, s_rx_on = 1'b0;
  logic [7:0] init_ar = '0, init_aw = '0, init_w = '0, init_r = '0, init_b = '0;
  logic link_up;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct { logic [31:0] addr; logic [3:0] id; int vis; } aw_beat_t;
  aw_beat_t awq[$];
  int ret_q[$];

  aib_axi_lite_bridge_if m_if ();
  aib_axi_lite_bridge_if s_if ();

  aib_axi_lite_bridge #(.LINK_LAT(LAT), .RX_DEPTH(DEPTH)) dut (
    .m_clk_wr(clk), .m_rst_wr_n(rst_n), .i_conf_done(conf_done),
    .m_tx_online(m_tx_on), .m_rx_online(m_rx_on), .s_tx_online(s_tx_on), .s_rx_online(s_rx_on),
    .m_init_ar_credit(init_ar), .m_init_aw_credit(init_aw), .m_init_w_credit(init_w),
    .s_init_r_credit(init_r), .s_init_b_credit(init_b),
    .m_axi(m_if), .s_axi(s_if), .link_up(link_up));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, rdy, exp_rdy, head, got;
    logic [31:0] a;
    logic [3:0] id;
    int accepted, returned, acc_w;

    m_if.awvalid = 0; m_if.awaddr = '0; m_if.awid = '0; m_if.awlen = '0; m_if.awsize = '0; m_if.awburst = '0;
    m_if.wvalid = 0; m_if.wdata = '0; m_if.wstrb = '0; m_if.wlast = 0; m_if.bready = 0;
    m_if.arvalid = 0; m_if.araddr = '0; m_if.arid = '0; m_if.arlen = '0; m_if.arsize = '0; m_if.arburst = '0;
    m_if.rready = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.arready = 0;
    s_if.bvalid = 0; s_if.bresp = '0; s_if.bid = '0;
    s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = '0; s_if.rid = '0; s_if.rlast = 0;

    // reset state
    #10;
    chk("rst_link_up", link_up, 0);
    chk("rst_m_awready", m_if.awready, 0);
    chk("rst_m_wready", m_if.wready, 0);
    chk("rst_m_arready", m_if.arready, 0);
    chk("rst_s_bready", s_if.bready, 0);
    chk("rst_s_awvalid", s_if.awvalid, 0);
    chk("rst_m_rvalid", m_if.rvalid, 0);

    // bring-up
    #90 rst_n = 1;
    #20;
    init_ar = 8; init_aw = 8; init_w = 8; init_r = 8; init_b = 8;
    conf_done = 1; m_tx_on = 1; m_rx_on = 1; s_tx_on = 1; s_rx_on = 1;
    #1;
    chk("up_link_up", link_up, 1);
    chk("up_awready_first", m_if.awready, 0);
    tick;
    chk("up_awready", m_if.awready, 1);
    chk("up_wready", m_if.wready, 1);
    chk("up_arready", m_if.arready, 1);
    chk("up_bvalid", m_if.bvalid, 0);
    chk("up_rvalid", m_if.rvalid, 0);

    // write: AW + W across, then B back
    m_if.awvalid = 1; m_if.awaddr = 32'h1000; m_if.awid = 4'h3; m_if.awlen = 8'd3; m_if.awsize = 3'd3; m_if.awburst = 2'd1;
    m_if.wvalid = 1; m_if.wdata = 64'h12345678; m_if.wstrb = 8'hFF; m_if.wlast = 1;
    tick;
    m_if.awvalid = 0; m_if.wvalid = 0;
    repeat (LAT) tick;
    chk("wr_aw_early", s_if.awvalid, 0);
    tick;
    chk("wr_awvalid", s_if.awvalid, 1);
    chk("wr_awaddr", s_if.awaddr, 32'h1000);
    chk("wr_awlen", s_if.awlen, 8'd3);
    chk("wr_awburst", s_if.awburst, 2'd1);
    chk("wr_wvalid", s_if.wvalid, 1);
    chk("wr_wdata", s_if.wdata, 64'h12345678);
    chk("wr_wstrb", s_if.wstrb, 8'hFF);
    s_if.awready = 1; s_if.wready = 1;
    tick;
    s_if.awready = 0; s_if.wready = 0;
    chk("wr_aw_popped", s_if.awvalid, 0);
    s_if.bvalid = 1; s_if.bresp = 2'd0; s_if.bid = 4'h3;
    #1 chk("wr_bready", s_if.bready, 1);
    tick;
    s_if.bvalid = 0;
    repeat (LAT) tick;
    chk("wr_b_early", m_if.bvalid, 0);
    tick;
    chk("wr_bvalid", m_if.bvalid, 1);
    chk("wr_bresp", m_if.bresp, 2'd0);
    chk("wr_bid", m_if.bid, 4'h3);
    m_if.bready = 1;
    tick;
    m_if.bready = 0;

    // read: AR across, R back
    m_if.arvalid = 1; m_if.araddr = 32'h2000; m_if.arid = 4'h5;
    tick;
    m_if.arvalid = 0;
    repeat (LAT) tick;
    chk("rd_ar_early", s_if.arvalid, 0);
    tick;
    chk("rd_arvalid", s_if.arvalid, 1);
    chk("rd_araddr", s_if.araddr, 32'h2000);
    chk("rd_arid", s_if.arid, 4'h5);
    s_if.arready = 1;
    tick;
    s_if.arready = 0;
    s_if.rvalid = 1; s_if.rdata = 64'h9ABCDEF0; s_if.rresp = 2'd0; s_if.rid = 4'h5; s_if.rlast = 1;
    tick;
    s_if.rvalid = 0;
    repeat (LAT + 1) tick;
    chk("rd_rvalid", m_if.rvalid, 1);
    chk("rd_rdata", m_if.rdata, 64'h9ABCDEF0);
    chk("rd_rresp", m_if.rresp, 2'd0);
    chk("rd_rid", m_if.rid, 4'h5);
    chk("rd_rlast", m_if.rlast, 1);
    m_if.rready = 1;
    tick;
    m_if.rready = 0;
    chk("rd_r_popped", m_if.rvalid, 0);

    // link drop with an AW in flight
    m_if.awvalid = 1; m_if.awaddr = 32'h3000; m_if.awid = 4'h7;
    tick;
    s_rx_on = 0;
    #1;
    chk("drop_link_up", link_up, 0);
    chk("drop_awready", m_if.awready, 0);
    repeat (LAT + 1) tick;
    m_if.awvalid = 0;
    chk("drop_delivered", s_if.awvalid, 1);
    chk("drop_addr", s_if.awaddr, 32'h3000);
    s_if.awready = 1;
    tick;
    s_if.awready = 0;
    chk("drop_no_extra", s_if.awvalid, 0);
    repeat (LAT + 2) tick;
    s_rx_on = 1;
    #1;
    chk("relink_link_up", link_up, 1);
    chk("relink_awready", m_if.awready, 1);
    tick;

    // randomized AW traffic: credits = init - accepted + returned
    accepted = 0; returned = 0;
    for (int n = 0; n < 300; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) == 0);
      a   = $urandom;
      id  = 4'($urandom);
      m_if.awvalid = v; m_if.awaddr = a; m_if.awid = id; s_if.awready = rdy;
      #1;
      while (ret_q.size() > 0 && ret_q[0] <= cyc) begin
        ret_q.delete(0);
        returned++;
      end
      exp_rdy = ((8 - accepted + returned) != 0);
      head    = (awq.size() > 0) && (awq[0].vis <= cyc);
      chk("rnd_awready", m_if.awready, exp_rdy);
      chk("rnd_awvalid", s_if.awvalid, head);
      if (head) begin
        chk("rnd_awaddr", s_if.awaddr, awq[0].addr);
        chk("rnd_awid", s_if.awid, awq[0].id);
      end
      if (v && exp_rdy) begin
        accepted++;
        awq.push_back('{a, id, cyc + LAT + 2});
      end
      if (head && rdy) begin
        awq.delete(0);
        ret_q.push_back(cyc + 1 + LAT);
      end
      tick;
    end
    m_if.awvalid = 0; s_if.awready = 0;

    // reset mid-burst with W beats queued
    m_if.wvalid = 1; m_if.wdata = 64'hDEAD_BEEF;
    repeat (3) tick;
    m_if.wvalid = 0;
    repeat (LAT + 1) tick;
    chk("mid_wvalid_pre", s_if.wvalid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_wvalid", s_if.wvalid, 0);
    chk("mid_rst_awvalid", s_if.awvalid, 0);
    chk("mid_rst_awready", m_if.awready, 0);
    chk("mid_rst_link_up", link_up, 0);
    init_aw = 2; init_w = 40; init_ar = 0;
    #10 rst_n = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      #1 got = m_if.awready;
    end
    chk("mid_relink_awready", got, 1);
    chk("mid_ar_blocked", m_if.arready, 0);
    chk("mid_w_discarded", s_if.wvalid, 0);

    // W credit saturates at RX_DEPTH
    acc_w = 0;
    for (int i = 0; i < 20; i++) begin
      m_if.wvalid = 1; m_if.wdata = {$urandom, $urandom};
      #1 if (m_if.wready) acc_w++;
      tick;
    end
    m_if.wvalid = 0;
    chk("w_sat_count", acc_w, DEPTH);
    chk("ar_still_blocked", m_if.arready, 0);

    // AW credit stall with init 2
    m_if.awvalid = 1; m_if.awaddr = 32'hA000_0001;
    tick;
    m_if.awaddr = 32'hA000_0002;
    #1 chk("stall_rdy2", m_if.awready, 1);
    tick;
    m_if.awaddr = 32'hA000_0003;
    #1 chk("stall_rdy0", m_if.awready, 0);
    repeat (LAT + 1) tick;
    #1;
    chk("stall_hold", m_if.awready, 0);
    chk("stall_svalid", s_if.awvalid, 1);
    chk("stall_first", s_if.awaddr, 32'hA000_0001);
    s_if.awready = 1;
    tick;
    s_if.awready = 0;
    repeat (LAT - 1) tick;
    #1 chk("stall_early", m_if.awready, 0);
    tick;
    #1;
    chk("stall_release", m_if.awready, 1);
    chk("stall_second", s_if.awaddr, 32'hA000_0002);
    tick;
    m_if.awvalid = 0;
    #1 chk("stall_spent", m_if.awready, 0);
    s_if.awready = 1;
    tick;
    s_if.awready = 0;
    repeat (LAT) tick;
    chk("stall_third_valid", s_if.awvalid, 1);
    chk("stall_third", s_if.awaddr, 32'hA000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
